imm_ext_pipe: RTL
=================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 8, width of the illegal-ImmSrc counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 instr  input  25  instruction bits [31:7], indexed [31:7].
REQ-008 ImmSrc  input  3  immediate format select.
REQ-009 out_valid  output  1  ImmExt/out_illegal hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 ImmExt  output  XLEN  extended immediate.
REQ-012 out_illegal  output  1  result came from an illegal ImmSrc.
REQ-013 illegal_cnt  output  CNT_W  count of accepted illegal requests.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 ImmSrc decode, with s = instr[31] replicated to XLEN:
- 000 I-sext: s..., instr[31:20]
- 110 I-zext: zeros, instr[31:20]
- 001 S: s..., instr[31:25], instr[11:7]
- 010 B: s..., instr[7], instr[30:25], instr[11:8], 0
- 100 J: s..., instr[19:12], instr[20], instr[30:21], 0
- 101 U: s... (XLEN=64 only), instr[31:12], 12 zeros
REQ-016 ImmSrc 011 and 111 are illegal; ImmExt = 0 and out_illegal = 1 for such results. out_illegal = 0 for all legal codes.
REQ-017 Storage: one output register (OR) driving the outputs, plus one skid register (SK); each has its own valid bit.
REQ-018 in_ready is registered and equals !SK.valid.
REQ-019 Latency: a request accepted at edge N appears on out_valid/ImmExt after edge N, i.e. in cycle N+1, when OR is empty or draining.
REQ-020 On an accept, if OR is empty or its output transfer occurs in the same cycle, the decoded result loads OR.
REQ-021 On an accept, if OR is full and out_ready = 0, the decoded result loads SK.
REQ-022 When SK is full and an OR output transfer occurs, SK moves into OR and SK empties; no accept is possible that cycle (in_ready = 0).
REQ-023 Otherwise, an output transfer with no refill clears OR.valid.
REQ-024 Results leave in strict acceptance order; none are dropped or duplicated.
REQ-025 With out_ready held at 1, throughput is one result per cycle.
REQ-026 While out_valid = 1 and out_ready = 0, ImmExt and out_illegal hold stable.
REQ-027 illegal_cnt increments by 1 on each accepted illegal request and saturates at 2^CNT_W-1; it never wraps.
REQ-028 Decode is evaluated on the instr/ImmSrc sampled at accept; later input changes do not affect stored results.

Reset
REQ-029 While rst_n = 0 at a rising edge, the following clear: OR.valid, SK.valid, OR/SK data, illegal_cnt. Consequently out_valid = 0, ImmExt = 0, out_illegal = 0, in_ready = 1 from the next cycle.
REQ-030 Reset asserted mid-stream discards all buffered results; no output transfer is reported for them after reset.
REQ-031 in_valid during reset is ignored; the first accept can occur in the cycle after rst_n returns to 1.

Verification
REQ-032 instr = 0xFFF00093 bits [31:7], ImmSrc = 000, out_ready = 1 -> next cycle ImmExt = 0xFFFFFFFF; with ImmSrc = 110 -> 0x00000FFF.
REQ-033 0xFE112E23 with ImmSrc = 001 -> 0xFFFFFFFC; 0xFFDFF06F with ImmSrc = 100 -> 0xFFFFFFFC; 0x123450B7 with ImmSrc = 101 -> 0x12345000 (XLEN=64: 0x0000000012345000).
REQ-034 Back-pressure: out_ready = 0, three requests A, B, C offered back-to-back -> A and B accepted, in_ready = 0 with C pending; release out_ready -> A, B, C emitted in order, none lost.
REQ-035 CNT_W = 2, five accepted ImmSrc = 011 requests -> each gives ImmExt = 0 and out_illegal = 1; illegal_cnt reads 1, 2, 3, 3, 3.
REQ-036 rst_n pulsed low with OR and SK full -> next cycle out_valid = 0, in_ready = 1, illegal_cnt = 0; the stale results never appear.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// RISC-V immediate extender behind a two-entry valid/ready pipeline (output register plus skid register).
// Also keeps a saturating count of accepted requests that carry an illegal ImmSrc code.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr,
  input  logic [2:0]       ImmSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic            decIllegal;
  logic [XLEN-1:0] decImm;

  logic            orValid_q, orValid_d;
  logic [XLEN-1:0] orImm_q, orImm_d;
  logic            orIll_q, orIll_d;
  logic            skValid_q, skValid_d;
  logic [XLEN-1:0] skImm_q, skImm_d;
  logic            skIll_q, skIll_d;
  logic            inReady_q, inReady_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic drain;

  // Sign extension comes from casting a signed field to XLEN bits.
  always_comb begin
    decIllegal = 1'b0;
    decImm     = '0;
    unique case (ImmSrc)
      3'b000: decImm = XLEN'($signed(instr[31:20]));
      3'b110: decImm = XLEN'(instr[31:20]);
      3'b001: decImm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: decImm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b100: decImm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b101: decImm = XLEN'($signed({instr[31:12], 12'b0}));
      default: decIllegal = 1'b1;
    endcase
  end

  assign accept = in_valid && inReady_q;
  assign drain  = orValid_q && out_ready;

  // An accept can only happen while SK is empty, so SK refilling OR and a new accept never collide.
  always_comb begin
    orValid_d = orValid_q;
    orImm_d   = orImm_q;
    orIll_d   = orIll_q;
    skValid_d = skValid_q;
    skImm_d   = skImm_q;
    skIll_d   = skIll_q;
    cnt_d     = cnt_q;

    if (skValid_q) begin
      if (drain) begin
        orImm_d   = skImm_q;
        orIll_d   = skIll_q;
        skValid_d = 1'b0;
      end
    end else if (accept) begin
      if (!orValid_q || drain) begin
        orValid_d = 1'b1;
        orImm_d   = decImm;
        orIll_d   = decIllegal;
      end else begin
        skValid_d = 1'b1;
        skImm_d   = decImm;
        skIll_d   = decIllegal;
      end
    end else if (drain) begin
      orValid_d = 1'b0;
    end

    if (accept && decIllegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    inReady_d = !skValid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orValid_q <= 1'b0;
      orImm_q   <= '0;
      orIll_q   <= 1'b0;
      skValid_q <= 1'b0;
      skImm_q   <= '0;
      skIll_q   <= 1'b0;
      inReady_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      orValid_q <= orValid_d;
      orImm_q   <= orImm_d;
      orIll_q   <= orIll_d;
      skValid_q <= skValid_d;
      skImm_q   <= skImm_d;
      skIll_q   <= skIll_d;
      inReady_q <= inReady_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = orValid_q;
  assign ImmExt      = orImm_q;
  assign out_illegal = orIll_q;
  assign illegal_cnt = cnt_q;

endmodule
